// File: rtl/dtm_dbus_arbiter.sv
// dtm_dbus_arbiter: shares one Debug Module dbus port between two DTM-style
// requesters. Exactly one transaction is in flight at a time. The response
// goes back only to the requester that issued the request. When both
// requesters are valid at once, the port that was not served last wins.
module dtm_dbus_arbiter #(
    parameter int DEBUG_DATA_BITS = 34,
    parameter int DEBUG_ADDR_BITS = 5,
    parameter int DEBUG_OP_BITS   = 2
) (
    input  logic                                                    jtag_TCK,
    input  logic                                                    jtag_TRST,
    input  logic                                                    req0_valid,
    output logic                                                    req0_ready,
    input  logic [DEBUG_OP_BITS+DEBUG_ADDR_BITS+DEBUG_DATA_BITS-1:0] req0_bits,
    output logic                                                    resp0_valid,
    input  logic                                                    resp0_ready,
    output logic [DEBUG_OP_BITS+DEBUG_DATA_BITS-1:0]                 resp0_bits,
    input  logic                                                    req1_valid,
    output logic                                                    req1_ready,
    input  logic [DEBUG_OP_BITS+DEBUG_ADDR_BITS+DEBUG_DATA_BITS-1:0] req1_bits,
    output logic                                                    resp1_valid,
    input  logic                                                    resp1_ready,
    output logic [DEBUG_OP_BITS+DEBUG_DATA_BITS-1:0]                 resp1_bits,
    output logic                                                    dm_req_valid,
    input  logic                                                    dm_req_ready,
    output logic [DEBUG_OP_BITS+DEBUG_ADDR_BITS+DEBUG_DATA_BITS-1:0] dm_req_bits,
    input  logic                                                    dm_resp_valid,
    output logic                                                    dm_resp_ready,
    input  logic [DEBUG_OP_BITS+DEBUG_DATA_BITS-1:0]                 dm_resp_bits
);

    localparam int REQ_BITS  = DEBUG_OP_BITS + DEBUG_ADDR_BITS + DEBUG_DATA_BITS;
    localparam int RESP_BITS = DEBUG_OP_BITS + DEBUG_DATA_BITS;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        RETURN = 2'd3
    } state_t;

    state_t                 state;
    logic                   owner;     // requester that owns the transaction in flight
    logic                   last;      // requester served most recently
    logic [REQ_BITS-1:0]    req_reg;
    logic [RESP_BITS-1:0]   resp_reg;
    logic                   grant0;
    logic                   grant1;
    logic                   owner_ack;

    // Round-robin grant and handshake/valid decode from the current state.
    always_comb begin
        // NOTE: every output of this block gets a value before any condition
        // so that no path leaves a signal unassigned and a latch is inferred.
        grant0        = req0_valid & (~req1_valid | last);
        grant1        = req1_valid & ~grant0;
        // Readies stay low while reset is held, even if a requester is valid.
        req0_ready    = (state == IDLE) & ~jtag_TRST & grant0;
        req1_ready    = (state == IDLE) & ~jtag_TRST & grant1;
        dm_req_valid  = (state == ISSUE);
        dm_req_bits   = req_reg;
        dm_resp_ready = (state == WAIT);
        resp0_valid   = (state == RETURN) & ~owner;
        resp1_valid   = (state == RETURN) &  owner;
        resp0_bits    = resp_reg;
        resp1_bits    = resp_reg;
        owner_ack     = owner ? resp1_ready : resp0_ready;
    end

    // Transaction FSM: accept, forward to the DM, capture, return to owner.
    always_ff @(posedge jtag_TCK or posedge jtag_TRST) begin
        if (jtag_TRST) begin
            // An abandoned transaction simply disappears: nothing is returned.
            state    <= IDLE;
            owner    <= 1'b0;
            last     <= 1'b1;
            req_reg  <= '0;
            resp_reg <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // register samples the values from before this clock edge.
            case (state)
                IDLE: begin
                    if (grant0 | grant1) begin
                        req_reg <= grant0 ? req0_bits : req1_bits;
                        owner   <= grant1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (dm_req_ready) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (dm_resp_valid) begin
                        resp_reg <= dm_resp_bits;
                        state    <= RETURN;
                    end
                end
                RETURN: begin
                    if (owner_ack) begin
                        last  <= owner;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dtm_dbus_arbiter.sv
// Testbench for dtm_dbus_arbiter: directed scenarios plus randomized traffic,
// all checked cycle by cycle against a transaction-level reference model.
module tb_dtm_dbus_arbiter;

    localparam int DATA_BITS = 34;
    localparam int ADDR_BITS = 5;
    localparam int OP_BITS   = 2;
    localparam int REQ_BITS  = OP_BITS + ADDR_BITS + DATA_BITS;
    localparam int RESP_BITS = OP_BITS + DATA_BITS;

    logic                 clk = 1'b0;
    logic                 trst;
    logic                 req0_valid, req0_ready, resp0_valid, resp0_ready;
    logic                 req1_valid, req1_ready, resp1_valid, resp1_ready;
    logic [REQ_BITS-1:0]  req0_bits, req1_bits, dm_req_bits;
    logic [RESP_BITS-1:0] resp0_bits, resp1_bits, dm_resp_bits;
    logic                 dm_req_valid, dm_req_ready, dm_resp_valid, dm_resp_ready;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: the single transaction in flight, seen as a record.
    bit                   m_active;     // a request has been accepted and not yet returned
    bit                   m_fwd;        // the DM has accepted it
    bit                   m_cap;        // the DM has answered it
    int                   m_port;
    int                   m_last;       // port served most recently
    logic [REQ_BITS-1:0]  m_req;
    logic [RESP_BITS-1:0] m_resp;
    int                   served;
    int                   grants[$];

    dtm_dbus_arbiter #(
        .DEBUG_DATA_BITS(DATA_BITS),
        .DEBUG_ADDR_BITS(ADDR_BITS),
        .DEBUG_OP_BITS(OP_BITS)
    ) dut (
        .jtag_TCK(clk),
        .jtag_TRST(trst),
        .req0_valid(req0_valid),
        .req0_ready(req0_ready),
        .req0_bits(req0_bits),
        .resp0_valid(resp0_valid),
        .resp0_ready(resp0_ready),
        .resp0_bits(resp0_bits),
        .req1_valid(req1_valid),
        .req1_ready(req1_ready),
        .req1_bits(req1_bits),
        .resp1_valid(resp1_valid),
        .resp1_ready(resp1_ready),
        .resp1_bits(resp1_bits),
        .dm_req_valid(dm_req_valid),
        .dm_req_ready(dm_req_ready),
        .dm_req_bits(dm_req_bits),
        .dm_resp_valid(dm_resp_valid),
        .dm_resp_ready(dm_resp_ready),
        .dm_resp_bits(dm_resp_bits)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0;
        m_fwd    = 0;
        m_cap    = 0;
        m_port   = 0;
        m_last   = 1;
        m_resp   = '0;
    endtask

    // One clock cycle. Called at a falling edge with inputs already driven:
    // compares outputs against the model, advances the model by the
    // handshakes that happen at the next rising edge, ends at the next fall.
    task automatic step();
        int   winner;
        logic e_r0, e_r1;
        #1;
        if (trst) model_reset();
        winner = (req0_valid && req1_valid) ? 1 - m_last : (req0_valid ? 0 : 1);
        e_r0 = !trst && !m_active && req0_valid && winner == 0;
        e_r1 = !trst && !m_active && req1_valid && winner == 1;
        check("req0_ready", req0_ready, e_r0);
        check("req1_ready", req1_ready, e_r1);
        check("dm_req_valid", dm_req_valid, m_active && !m_fwd);
        if (m_active && !m_fwd) check("dm_req_bits", dm_req_bits, m_req);
        check("dm_resp_ready", dm_resp_ready, m_active && m_fwd && !m_cap);
        check("resp0_valid", resp0_valid, m_active && m_cap && m_port == 0);
        check("resp1_valid", resp1_valid, m_active && m_cap && m_port == 1);
        if (m_active && m_cap) check("resp_bits", (m_port == 0) ? resp0_bits : resp1_bits, m_resp);
        if (!trst) begin
            if (!m_active) begin
                if (e_r0 || e_r1) begin
                    m_active = 1;
                    m_fwd    = 0;
                    m_cap    = 0;
                    m_port   = e_r0 ? 0 : 1;
                    m_req    = e_r0 ? req0_bits : req1_bits;
                    grants.push_back(m_port);
                end
            end else if (!m_fwd) begin
                if (dm_req_ready) m_fwd = 1;
            end else if (!m_cap) begin
                if (dm_resp_valid) begin
                    m_cap  = 1;
                    m_resp = dm_resp_bits;
                end
            end else if ((m_port == 0) ? resp0_ready : resp1_ready) begin
                m_active = 0;
                m_last   = m_port;
                served++;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        req0_valid    = 0;
        req1_valid    = 0;
        resp0_ready   = 0;
        resp1_ready   = 0;
        dm_req_ready  = 0;
        dm_resp_valid = 0;
        req0_bits     = '0;
        req1_bits     = '0;
        dm_resp_bits  = '0;
    endtask

    task automatic do_reset();
        trst = 1;
        step();
        step();
        trst = 0;
        step();
    endtask

    logic [REQ_BITS-1:0]  t2_req;
    logic [RESP_BITS-1:0] t2_resp;
    int                   start;
    bit                   done;

    initial begin
        trst = 1;
        idle_inputs();
        model_reset();
        served = 0;
        @(negedge clk);
        do_reset();

        // Reset state: nothing valid, nothing ready, with no stimulus.
        check("rst_req0_ready", req0_ready, 0);
        check("rst_dm_req_valid", dm_req_valid, 0);
        check("rst_dm_resp_ready", dm_resp_ready, 0);
        check("rst_resp_valids", {resp0_valid, resp1_valid}, 2'b00);

        // Single op: exact latency and pass-through values.
        t2_req  = {5'h10, 34'h1, 2'd2};
        t2_resp = {34'hABC, 2'd0};
        req0_valid   = 1;
        req0_bits    = t2_req;
        dm_req_ready = 1;
        step();
        check("t2_dm_req_valid", dm_req_valid, 1);
        check("t2_dm_req_bits", dm_req_bits, t2_req);
        req0_valid = 0;
        step();
        step();
        step();
        dm_resp_valid = 1;
        dm_resp_bits  = t2_resp;
        step();
        check("t2_resp0_valid", resp0_valid, 1);
        check("t2_resp0_bits", resp0_bits, t2_resp);
        check("t2_resp1_valid", resp1_valid, 0);
        dm_resp_valid = 0;
        resp0_ready   = 1;
        step();
        check("t2_served", served, 1);
        idle_inputs();

        // Reset mid-WAIT: transaction abandoned, next req0 granted, no stale return.
        req0_valid   = 1;
        req0_bits    = REQ_BITS'({$urandom, $urandom});
        dm_req_ready = 1;
        done = 0;
        for (int i = 0; i < 10 && !done; i++) begin
            step();
            req0_valid = 0;
            done = m_fwd && !m_cap;
        end
        if (!done) check("t1_reach_wait_timeout", 0, 1);
        req0_valid = 1;
        trst = 1;
        step();
        check("t1_in_reset_req0_ready", req0_ready, 0);
        check("t1_in_reset_dm_resp_ready", dm_resp_ready, 0);
        trst          = 0;
        dm_resp_valid = 1;
        dm_resp_bits  = RESP_BITS'({$urandom, $urandom});
        resp0_ready   = 1;
        start = served;
        for (int i = 0; i < 20 && served == start; i++) step();
        check("t1_served_after_reset", served, start + 1);
        check("t1_granted_port", grants[$], 0);
        idle_inputs();
        step();

        // Tie from reset: both valid continuously, grants must alternate 0,1,0,1.
        do_reset();
        grants.delete();
        req0_valid = 1;
        req1_valid = 1;
        dm_req_ready = 1;
        dm_resp_valid = 1;
        resp0_ready = 1;
        resp1_ready = 1;
        for (int i = 0; i < 40 && grants.size() < 4; i++) begin
            req0_bits    = REQ_BITS'({$urandom, $urandom});
            req1_bits    = REQ_BITS'({$urandom, $urandom});
            dm_resp_bits = RESP_BITS'({$urandom, $urandom});
            step();
        end
        check("t3_grant_count", grants.size(), 4);
        for (int i = 0; i < 4 && i < grants.size(); i++)
            check($sformatf("t3_grant%0d", i), grants[i], i % 2);
        idle_inputs();
        for (int i = 0; i < 10 && m_active; i++) begin
            resp0_ready = 1;
            resp1_ready = 1;
            dm_req_ready = 1;
            dm_resp_valid = 1;
            step();
        end
        idle_inputs();

        // DM backpressure: bits held and dm_resp_ready low throughout ISSUE.
        req1_valid = 1;
        req1_bits  = REQ_BITS'({$urandom, $urandom});
        step();
        req1_valid = 0;
        for (int i = 0; i < 5; i++) begin
            dm_resp_valid = 1;
            step();
            check("t4_dm_resp_ready", dm_resp_ready, 0);
        end
        dm_resp_valid = 0;
        dm_req_ready  = 1;
        step();
        dm_req_ready  = 0;

        // Slow return to port 1 while req0 waits for IDLE.
        dm_resp_valid = 1;
        dm_resp_bits  = RESP_BITS'({$urandom, $urandom});
        step();
        dm_resp_valid = 0;
        req0_valid    = 1;
        req0_bits     = REQ_BITS'({$urandom, $urandom});
        for (int i = 0; i < 20; i++) step();
        check("t5_resp1_held", resp1_valid, 1);
        check("t5_req0_blocked", req0_ready, 0);
        resp1_ready = 1;
        step();
        resp1_ready = 0;
        start = grants.size();
        step();
        check("t5_req0_granted", grants.size(), start + 1);
        req0_valid   = 0;
        dm_req_ready = 1;
        dm_resp_valid = 1;
        resp0_ready  = 1;
        for (int i = 0; i < 10 && m_active; i++) step();
        idle_inputs();

        // Spurious DM response in IDLE is ignored.
        dm_resp_valid = 1;
        dm_resp_bits  = RESP_BITS'({$urandom, $urandom});
        for (int i = 0; i < 5; i++) step();
        check("t6_dm_resp_ready", dm_resp_ready, 0);
        idle_inputs();

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 4000; i++) begin
            trst          = ($urandom_range(0, 499) == 0);
            req0_valid    = ($urandom_range(0, 9) < 5);
            req1_valid    = ($urandom_range(0, 9) < 5);
            req0_bits     = REQ_BITS'({$urandom, $urandom});
            req1_bits     = REQ_BITS'({$urandom, $urandom});
            dm_req_ready  = ($urandom_range(0, 9) < 5);
            dm_resp_valid = ($urandom_range(0, 9) < 4);
            dm_resp_bits  = RESP_BITS'({$urandom, $urandom});
            resp0_ready   = ($urandom_range(0, 9) < 4);
            resp1_ready   = ($urandom_range(0, 9) < 4);
            step();
        end
        trst = 0;
        check("rand_some_served", served > 100, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
